// File: rtl/fpm_pkg.sv
// Shared types and helpers for the sequential floating-point multiplier.
// Field helpers work on a 64-bit container so any supported format fits.
package fpm_pkg;

  typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

  function automatic int unsigned bias_f(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned exp_max_f(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

  function automatic logic sign_of(input logic [63:0] x, input int unsigned w);
    logic [63:0] t;
    t = x >> (w - 1);
    return t[0];
  endfunction

  function automatic logic [63:0] exp_of(input logic [63:0] x, input int unsigned exp_w,
                                         input int unsigned man_w);
    return (x >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] frac_of(input logic [63:0] x, input int unsigned man_w);
    return x & ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fpm_round_norm.sv
// Combinational normalise, round-to-nearest-even and pack of a raw mantissa product.
// Saturates to infinity on exponent overflow and flushes to zero on underflow.
module fpm_round_norm
  import fpm_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W    = EXP_W + MAN_W + 1,
  localparam int unsigned PW   = 2 * MAN_W + 2
) (
  input  logic [PW-1:0]           i_prod,
  input  logic signed [EXP_W+1:0] i_esum,
  input  logic                    i_sign,
  output logic [W-1:0]            o_m,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W + 2)'(bias_f(EXP_W));
  localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W + 2)'(exp_max_f(EXP_W));
  localparam logic signed [EXP_W+1:0] ZERO_S = '0;

  logic                    w_top, w_lost, w_guard, w_sticky, w_round_up, w_carry;
  logic [PW-1:0]           w_sh;
  logic [MAN_W:0]          w_mant;
  logic [MAN_W+1:0]        w_mant_r;
  logic [MAN_W-1:0]        w_frac;
  logic signed [EXP_W+1:0] w_e;
  logic                    w_unused;

  always_comb begin
    w_top      = i_prod[PW-1];
    w_sh       = w_top ? (i_prod >> 1) : i_prod;
    // The bit shifted out by normalisation still counts toward sticky.
    w_lost     = w_top & i_prod[0];
    w_mant     = w_sh[2*MAN_W:MAN_W];
    w_guard    = w_sh[MAN_W-1];
    w_sticky   = (|w_sh[MAN_W-2:0]) | w_lost;
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    w_mant_r   = {1'b0, w_mant} + {{(MAN_W + 1){1'b0}}, w_round_up};
    w_carry    = w_mant_r[MAN_W+1];
    w_frac     = w_carry ? '0 : w_mant_r[MAN_W-1:0];
    w_e        = i_esum - BIAS_S + $signed({{(EXP_W + 1){1'b0}}, w_top})
                 + $signed({{(EXP_W + 1){1'b0}}, w_carry});

    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    o_m         = {i_sign, w_e[EXP_W-1:0], w_frac};
    if (w_e >= EMAX_S) begin
      o_m        = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_overflow = 1'b1;
    end else if (w_e <= ZERO_S) begin
      o_m         = {i_sign, {(W - 1){1'b0}}};
      o_underflow = 1'b1;
    end
  end

  assign w_unused = ^{w_mant_r[MAN_W], w_sh[PW-1]};

endmodule

// File: rtl/fpm_seq_param.sv
// Parametrised shift-add floating-point multiplier with valid/ready on both sides.
// One multiplier bit per cycle; zero operands bypass the multiply entirely.
module fpm_seq_param
  import fpm_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W    = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] m,
  output logic         overflow,
  output logic         underflow,
  output logic         busy
);

  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned CW = $clog2(MAN_W + 1);

  state_e                  r_state, w_state_d;
  logic                    r_sign;
  logic signed [EXP_W+1:0] r_esum;
  logic [PW-1:0]           r_mcand, r_acc;
  logic [MAN_W:0]          r_mplier;
  logic [CW-1:0]           r_cnt;
  logic [W-1:0]            r_m;
  logic                    r_ovf, r_unf;

  logic                    w_sign, w_zero, w_accept, w_last;
  logic [EXP_W-1:0]        w_ea, w_eb;
  logic [MAN_W-1:0]        w_fa, w_fb;
  logic [W-1:0]            w_rn_m;
  logic                    w_rn_ovf, w_rn_unf;

  assign w_sign   = sign_of(64'(a), W) ^ sign_of(64'(b), W);
  assign w_ea     = EXP_W'(exp_of(64'(a), EXP_W, MAN_W));
  assign w_eb     = EXP_W'(exp_of(64'(b), EXP_W, MAN_W));
  assign w_fa     = MAN_W'(frac_of(64'(a), MAN_W));
  assign w_fb     = MAN_W'(frac_of(64'(b), MAN_W));
  assign w_zero   = (w_ea == '0) || (w_eb == '0);
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CW'(MAN_W - 1));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = w_zero ? StDone : StMul;
      StMul:   if (w_last) w_state_d = StNorm;
      StNorm:  w_state_d = StDone;
      StDone:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_esum   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_m      <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_sign   <= w_sign;
            r_esum   <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb});
            // Accumulator starts from the bit-0 partial product, so MUL needs MAN_W cycles.
            r_acc    <= w_fb[0] ? PW'({1'b1, w_fa}) : '0;
            r_mcand  <= PW'({1'b1, w_fa}) << 1;
            r_mplier <= {1'b1, w_fb} >> 1;
            r_cnt    <= '0;
            if (w_zero) begin
              r_m   <= {w_sign, {(W - 1){1'b0}}};
              r_ovf <= 1'b0;
              r_unf <= 1'b0;
            end
          end
        end
        StMul: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        StNorm: begin
          r_m   <= w_rn_m;
          r_ovf <= w_rn_ovf;
          r_unf <= w_rn_unf;
        end
        default: ;
      endcase
    end
  end

  fpm_round_norm #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round_norm (
    .i_prod      (r_acc),
    .i_esum      (r_esum),
    .i_sign      (r_sign),
    .o_m         (w_rn_m),
    .o_overflow  (w_rn_ovf),
    .o_underflow (w_rn_unf)
  );

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign m         = r_m;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_fpm_seq_param.sv
// Directed bench for fpm_seq_param: vector table for single precision plus
// handshake, mid-operation reset and half-precision sequences.
module tb_fpm_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, overflow, underflow, busy;
  logic [31:0] a, b, m;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_ovf, h_unf, h_busy;
  logic [15:0] h_a, h_b, h_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpm_seq_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .m(m), .overflow(overflow),
    .underflow(underflow), .busy(busy)
  );

  fpm_seq_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .m(h_m), .overflow(h_ovf),
    .underflow(h_unf), .busy(h_busy)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] m;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Issue one operation and collect the result; out_ready is assumed high.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        output logic [31:0] rm, output logic rov, output logic run,
                        output int lat);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    rm = m; rov = overflow; run = underflow;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rm, held;
    logic        rov, run;
    int          lat;
    int          pulses;

    vecs[0] = '{"basic",   32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 25};
    vecs[1] = '{"sign",    32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, 25};
    vecs[2] = '{"zero",    32'h80000000, 32'h40490FDB, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[3] = '{"rne",     32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0, 25};
    vecs[4] = '{"carry",   32'h3F7FFFFF, 32'h3F800001, 32'h3F800000, 1'b0, 1'b0, 25};
    vecs[5] = '{"ovf",     32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 25};
    vecs[6] = '{"unf",     32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 25};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_m", 64'(m), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_unf", 64'(underflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, rm, rov, run, lat);
      chk({vecs[i].name, "_m"}, 64'(rm), 64'(vecs[i].m));
      chk({vecs[i].name, "_ovf"}, 64'(rov), 64'(vecs[i].ovf));
      chk({vecs[i].name, "_unf"}, 64'(run), 64'(vecs[i].unf));
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure: result must hold, second request must wait for IDLE.
    out_ready = 1'b0;
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hs_busy", 64'(busy), 64'd1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs_lat", 64'(lat), 64'd25);
    held = m;
    a = 32'h40000000; b = 32'h40400000; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hs_hold_m", 64'(m), 64'h40400000);
      chk("hs_hold_valid", 64'(out_valid), 64'd1);
      chk("hs_hold_ready", 64'(in_ready), 64'd0);
    end
    chk("hs_stable", 64'(m), 64'(held));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_exit_ready", 64'(in_ready), 64'd1);
    chk("hs_exit_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hs_second_busy", 64'(busy), 64'd1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs_second_m", 64'(m), 64'h40C00000);
    @(posedge clk); #1;

    // Reset in the middle of the multiply drops the operation silently.
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("mrst_no_pulse", 64'(pulses), 64'd0);
    run_op(32'hC0000000, 32'h40400000, rm, rov, run, lat);
    chk("mrst_after_m", 64'(rm), 64'hC0C00000);
    chk("mrst_after_lat", 64'(lat), 64'd25);

    // Half-precision instance.
    h_a = 16'h3E00; h_b = 16'h4000; h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 1;
    while (!h_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("half_m", 64'(h_m), 64'h4200);
    chk("half_ovf", 64'(h_ovf), 64'd0);
    chk("half_unf", 64'(h_unf), 64'd0);
    chk("half_lat", 64'(lat), 64'd12);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
